// File: rtl/mem_loader_pkg.sv
// Shared definitions for the boot-time memory loader: FSM states, error codes, frame sync byte.
// No logic of its own.
// No flow control.
package mem_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_D_HI,
    ST_D_LO,
    ST_CS_HI,
    ST_CS_LO,
    ST_VERIFY,
    ST_DONE,
    ST_ERROR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Inter-byte timeout only runs while a frame is being received.
  function automatic logic in_frame(state_e s);
    return (s inside {ST_LEN_HI, ST_LEN_LO, ST_D_HI, ST_D_LO, ST_CS_HI, ST_CS_LO});
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Byte stream from the serial receiver plus the memory-mapped bus driven during boot.
// No logic; wiring bundle only.
// rx stream has no backpressure; memory bus is fixed-latency read, strobed write.
interface mem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] mem_out;
  logic [15:0] mem_address;
  logic        mem_load;
  logic [15:0] mem_in;

  modport master (
    input  rx_data, rx_valid, mem_out,
    output mem_address, mem_load, mem_in
  );

  modport slave (
    output rx_data, rx_valid, mem_out,
    input  mem_address, mem_load, mem_in
  );
endinterface

// File: rtl/mem_loader.sv
// Loads a framed program image from the rx byte stream into RAM, reads it back to verify the checksum, then releases the CPU.
// Write strobe one cycle after each D_LO byte; verify costs READ_LAT+1 cycles per word.
// No backpressure on rx: bytes arriving during VERIFY are dropped, idle gaps inside a frame are bounded by TIMEOUT.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int         RAM_WORDS = 8192,
  parameter int         READ_LAT  = 1,
  parameter int         TIMEOUT   = 1000000,
  parameter logic [7:0] SYNC      = SYNC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_loader_if.master bus,
  output logic         cpu_hold,
  output logic         done,
  output logic [1:0]   error
);

  localparam int          TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [1:0]  LAT      = 2'(READ_LAT);
  localparam logic [15:0] MAX_N    = 16'(RAM_WORDS);

  state_e        state_q, state_d;
  logic [7:0]    hi_q, hi_d;
  logic [15:0]   n_q, n_d, k_q, k_d, cs_q, cs_d, rsum_q, rsum_d;
  logic [1:0]    lat_q, lat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   mem_address_q, mem_address_d, mem_in_q, mem_in_d;
  logic          mem_load_q, mem_load_d;
  logic          cpu_hold_q, cpu_hold_d, done_q, done_d;
  err_e          error_q, error_d;

  logic [15:0]   word, k_inc, rsum_nx;
  logic          go_end, end_ok;
  err_e          end_err;

  // Next-state, byte assembly, write/verify addressing and timeout.
  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    n_d           = n_q;
    k_d           = k_q;
    cs_d          = cs_q;
    rsum_d        = rsum_q;
    lat_d         = lat_q;
    tmo_d         = '0;
    mem_address_d = mem_address_q;
    mem_in_d      = mem_in_q;
    mem_load_d    = 1'b0;
    cpu_hold_d    = cpu_hold_q;
    done_d        = done_q;
    error_d       = error_q;
    go_end        = 1'b0;
    end_ok        = 1'b0;
    end_err       = ERR_NONE;
    word          = {hi_q, bus.rx_data};
    k_inc         = k_q + 16'd1;
    rsum_nx       = rsum_q + bus.mem_out;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (bus.rx_valid && bus.rx_data == SYNC) begin
          state_d    = ST_LEN_HI;
          done_d     = 1'b0;
          error_d    = ERR_NONE;
          cpu_hold_d = 1'b1;
          k_d        = '0;
        end
      end
      ST_LEN_HI: if (bus.rx_valid) begin
        hi_d    = bus.rx_data;
        state_d = ST_LEN_LO;
      end
      ST_LEN_LO: if (bus.rx_valid) begin
        n_d = word;
        if (word > MAX_N) begin
          go_end  = 1'b1;
          end_err = ERR_LEN;
        end else if (word == 16'd0) begin
          state_d = ST_CS_HI;
        end else begin
          state_d = ST_D_HI;
        end
      end
      ST_D_HI: if (bus.rx_valid) begin
        hi_d    = bus.rx_data;
        state_d = ST_D_LO;
      end
      ST_D_LO: if (bus.rx_valid) begin
        mem_address_d = k_q;
        mem_in_d      = word;
        mem_load_d    = 1'b1;
        k_d           = k_inc;
        state_d       = (k_inc == n_q) ? ST_CS_HI : ST_D_HI;
      end
      ST_CS_HI: if (bus.rx_valid) begin
        hi_d    = bus.rx_data;
        state_d = ST_CS_LO;
      end
      ST_CS_LO: if (bus.rx_valid) begin
        cs_d   = word;
        k_d    = '0;
        rsum_d = '0;
        lat_d  = '0;
        if (n_q == 16'd0) begin
          // Empty image: the read-back sum is trivially zero.
          go_end  = 1'b1;
          end_ok  = (word == 16'd0);
          end_err = ERR_CSUM;
        end else begin
          state_d       = ST_VERIFY;
          mem_address_d = '0;
        end
      end
      ST_VERIFY: begin
        if (lat_q == LAT) begin
          rsum_d = rsum_nx;
          k_d    = k_inc;
          lat_d  = '0;
          if (k_inc == n_q) begin
            go_end  = 1'b1;
            end_ok  = (rsum_nx == cs_q);
            end_err = ERR_CSUM;
          end else begin
            mem_address_d = k_inc;
          end
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Idle gap counter; any received byte restarts it.
    if (in_frame(state_q) && !bus.rx_valid) begin
      if (tmo_q == TMO_LAST) begin
        go_end  = 1'b1;
        end_ok  = 1'b0;
        end_err = ERR_TIMEOUT;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (go_end) begin
      mem_address_d = '0;
      if (end_ok) begin
        state_d    = ST_DONE;
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
      end else begin
        state_d    = ST_ERROR;
        error_d    = end_err;
        done_d     = 1'b0;
        cpu_hold_d = 1'b1;
      end
    end
  end

  // State and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      hi_q          <= '0;
      n_q           <= '0;
      k_q           <= '0;
      cs_q          <= '0;
      rsum_q        <= '0;
      lat_q         <= '0;
      tmo_q         <= '0;
      mem_address_q <= '0;
      mem_in_q      <= '0;
      mem_load_q    <= 1'b0;
      cpu_hold_q    <= 1'b1;
      done_q        <= 1'b0;
      error_q       <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      n_q           <= n_d;
      k_q           <= k_d;
      cs_q          <= cs_d;
      rsum_q        <= rsum_d;
      lat_q         <= lat_d;
      tmo_q         <= tmo_d;
      mem_address_q <= mem_address_d;
      mem_in_q      <= mem_in_d;
      mem_load_q    <= mem_load_d;
      cpu_hold_q    <= cpu_hold_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign bus.mem_address = mem_address_q;
  assign bus.mem_in      = mem_in_q;
  assign bus.mem_load    = mem_load_q;
  assign cpu_hold        = cpu_hold_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule
